// File: rtl/spatz_bank_arbiter_pkg.sv
// Shared types for the Spatz hybrid cache/SPM bank arbiter.
// Bank geometry is fixed here; the arbiter modules only choose Latency/MaxStall.
package spatz_bank_arb_pkg;

    localparam int unsigned NumBanks      = 8;
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned BankAddrWidth = 8;
    localparam int unsigned StrbWidth     = DataWidth / 8;
    localparam int unsigned BankSelWidth  = $clog2(NumBanks);
    localparam int unsigned MemAddrWidth  = BankAddrWidth + BankSelWidth;

    // One bank access as seen by a data bank
    typedef struct packed {
        logic                     we;
        logic [BankAddrWidth-1:0] addr;
        logic [DataWidth-1:0]     data;
        logic [StrbWidth-1:0]     be;
    } bank_req_t;

    typedef enum logic {
        CACHE = 1'b0,
        SPM   = 1'b1
    } arb_sel_e;

    // Grant information carried alongside the bank read latency
    typedef struct packed {
        logic [NumBanks-1:0]     cache_rd;
        logic                    spm_rd;
        logic [BankSelWidth-1:0] spm_idx;
    } rsp_entry_t;

    function automatic logic [BankSelWidth:0] popcount(input logic [NumBanks-1:0] v);
        logic [BankSelWidth:0] n;
        n = '0;
        for (int i = 0; i < NumBanks; i++) n = n + {{BankSelWidth{1'b0}}, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/spatz_bank_arbiter_if.sv
// Bus bundle of the bank arbiter: SPM port, per-bank cache ports, bank side, perf.
// slave = arbiter side, master = requester/bank environment side.
interface spatz_bank_arbiter_if;
    import spatz_bank_arb_pkg::*;

    logic                                     spm_valid_i;
    logic                                     spm_ready_o;
    logic                                     spm_we_i;
    logic [MemAddrWidth-1:0]                  spm_addr_i;
    logic [DataWidth-1:0]                     spm_wdata_i;
    logic [StrbWidth-1:0]                     spm_be_i;
    logic                                     spm_rvalid_o;
    logic [DataWidth-1:0]                     spm_rdata_o;

    logic [NumBanks-1:0]                      cache_valid_i;
    logic [NumBanks-1:0]                      cache_ready_o;
    logic [NumBanks-1:0]                      cache_we_i;
    logic [NumBanks-1:0][BankAddrWidth-1:0]   cache_addr_i;
    logic [NumBanks-1:0][DataWidth-1:0]       cache_wdata_i;
    logic [NumBanks-1:0][StrbWidth-1:0]       cache_be_i;
    logic [NumBanks-1:0]                      cache_rvalid_o;
    logic [NumBanks-1:0][DataWidth-1:0]       cache_rdata_o;

    logic [NumBanks-1:0]                      bank_req_o;
    logic [NumBanks-1:0]                      bank_we_o;
    logic [NumBanks-1:0][BankAddrWidth-1:0]   bank_addr_o;
    logic [NumBanks-1:0][DataWidth-1:0]       bank_wdata_o;
    logic [NumBanks-1:0][StrbWidth-1:0]       bank_be_o;
    logic [NumBanks-1:0][DataWidth-1:0]       bank_rdata_i;

    logic [31:0]                              spm_stall_cnt_o;
    logic [31:0]                              cache_stall_cnt_o;

    modport slave (
        input  spm_valid_i, spm_we_i, spm_addr_i, spm_wdata_i, spm_be_i,
        input  cache_valid_i, cache_we_i, cache_addr_i, cache_wdata_i, cache_be_i,
        input  bank_rdata_i,
        output spm_ready_o, spm_rvalid_o, spm_rdata_o,
        output cache_ready_o, cache_rvalid_o, cache_rdata_o,
        output bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
        output spm_stall_cnt_o, cache_stall_cnt_o
    );

    modport master (
        output spm_valid_i, spm_we_i, spm_addr_i, spm_wdata_i, spm_be_i,
        output cache_valid_i, cache_we_i, cache_addr_i, cache_wdata_i, cache_be_i,
        output bank_rdata_i,
        input  spm_ready_o, spm_rvalid_o, spm_rdata_o,
        input  cache_ready_o, cache_rvalid_o, cache_rdata_o,
        input  bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o,
        input  spm_stall_cnt_o, cache_stall_cnt_o
    );

endinterface

// File: rtl/spatz_bank_arbiter_slice.sv
// One bank: SPM-priority arbitration with a starvation counter that forces a
// cache grant after MaxStall consecutive lost conflicts.
module spatz_bank_arb_slice
    import spatz_bank_arb_pkg::*;
#(
    parameter int unsigned MaxStall = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      spm_valid,
    input  bank_req_t spm_req,
    input  logic      cache_valid,
    input  bank_req_t cache_req,
    output logic      spm_gnt,
    output logic      cache_gnt,
    output logic      bank_vld,
    output bank_req_t bank_req
);

    localparam int unsigned CntW = $clog2(MaxStall + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            conflict, starve;
    arb_sel_e        sel;

    assign conflict = spm_valid && cache_valid;
    assign starve   = conflict && (cnt_q == CntW'(MaxStall));

    // Grant, payload mux and next starvation count
    always_comb begin
        spm_gnt   = spm_valid && !starve;
        cache_gnt = cache_valid && !spm_gnt;
        bank_vld  = spm_gnt || cache_gnt;
        sel       = spm_gnt ? SPM : CACHE;
        bank_req  = '0;
        if (bank_vld) bank_req = (sel == SPM) ? spm_req : cache_req;
        // only a lost conflict advances the count; anything else restarts it
        cnt_d     = (conflict && !starve) ? cnt_q + CntW'(1) : '0;
    end

    // Starvation counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spatz_bank_arbiter.sv
// Spatz bank arbiter: SPM decode, per-bank arbitration slices, read-response
// routing through a Latency-deep grant pipeline, optional stall counters
// (enabled with `define SPATZ_BANK_ARB_PERF_EN).
module spatz_bank_arbiter
    import spatz_bank_arb_pkg::*;
#(
    parameter int unsigned Latency  = 1,
    parameter int unsigned MaxStall = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    spatz_bank_arbiter_if.slave bus
);

    logic [BankSelWidth-1:0] sb;
    bank_req_t               spm_req;
    logic [NumBanks-1:0]     spm_bank_v, cache_v, spm_gnt, cache_gnt, bank_vld;
    bank_req_t               cache_req [NumBanks];
    bank_req_t               bank_q    [NumBanks];
    rsp_entry_t              rsp_in, rsp_out;
    rsp_entry_t              rsp_pipe  [Latency];

    assign sb      = bus.spm_addr_i[BankSelWidth-1:0];
    assign spm_req = '{we:   bus.spm_we_i,
                       addr: bus.spm_addr_i[MemAddrWidth-1:BankSelWidth],
                       data: bus.spm_wdata_i,
                       be:   bus.spm_be_i};

    for (genvar i = 0; i < NumBanks; i++) begin : g_bank
        // requests are masked during reset so nothing is granted or written
        assign spm_bank_v[i] = bus.spm_valid_i && !rst_i && (sb == BankSelWidth'(i));
        assign cache_v[i]    = bus.cache_valid_i[i] && !rst_i;
        assign cache_req[i]  = '{we:   bus.cache_we_i[i],
                                 addr: bus.cache_addr_i[i],
                                 data: bus.cache_wdata_i[i],
                                 be:   bus.cache_be_i[i]};

        spatz_bank_arb_slice #(.MaxStall(MaxStall)) u_slice (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .spm_valid   (spm_bank_v[i]),
            .spm_req     (spm_req),
            .cache_valid (cache_v[i]),
            .cache_req   (cache_req[i]),
            .spm_gnt     (spm_gnt[i]),
            .cache_gnt   (cache_gnt[i]),
            .bank_vld    (bank_vld[i]),
            .bank_req    (bank_q[i])
        );
    end

    assign bus.spm_ready_o   = |spm_gnt;
    assign bus.cache_ready_o = cache_gnt;
    assign bus.bank_req_o    = bank_vld;

    // Unpack the granted payloads onto the bank bus
    always_comb begin
        for (int i = 0; i < NumBanks; i++) begin
            bus.bank_we_o[i]    = bank_q[i].we;
            bus.bank_addr_o[i]  = bank_q[i].addr;
            bus.bank_wdata_o[i] = bank_q[i].data;
            bus.bank_be_o[i]    = bank_q[i].be;
        end
    end

    assign rsp_in = '{cache_rd: cache_gnt & ~bus.cache_we_i,
                      spm_rd:   bus.spm_ready_o && !bus.spm_we_i,
                      spm_idx:  sb};

    // Grant info shifts along with the bank read latency; reset drops it all
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < Latency; k++) rsp_pipe[k] <= '0;
        end else begin
            rsp_pipe[0] <= rsp_in;
            for (int k = 1; k < Latency; k++) rsp_pipe[k] <= rsp_pipe[k-1];
        end
    end

    assign rsp_out = rsp_pipe[Latency-1];

    assign bus.spm_rvalid_o   = rsp_out.spm_rd;
    assign bus.spm_rdata_o    = rsp_out.spm_rd ? bus.bank_rdata_i[rsp_out.spm_idx] : '0;
    assign bus.cache_rvalid_o = rsp_out.cache_rd;

    // Route bank read data to the cache ports, zero when not valid
    always_comb begin
        for (int i = 0; i < NumBanks; i++)
            bus.cache_rdata_o[i] = rsp_out.cache_rd[i] ? bus.bank_rdata_i[i] : '0;
    end

`ifdef SPATZ_BANK_ARB_PERF_EN
    logic [31:0] spm_stall_q, cache_stall_q;

    // Stall accounting; both counters wrap naturally at 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spm_stall_q   <= '0;
            cache_stall_q <= '0;
        end else begin
            if (bus.spm_valid_i && !bus.spm_ready_o) spm_stall_q <= spm_stall_q + 32'd1;
            cache_stall_q <= cache_stall_q
                           + 32'(popcount(bus.cache_valid_i & ~bus.cache_ready_o));
        end
    end

    assign bus.spm_stall_cnt_o   = spm_stall_q;
    assign bus.cache_stall_cnt_o = cache_stall_q;
`else
    assign bus.spm_stall_cnt_o   = '0;
    assign bus.cache_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spatz_bank_arbiter.sv
// Bench for spatz_bank_arbiter: three instances (Latency 1/2/3) share one
// stimulus stream; read responses are predicted into queues and checked on output.
module tb_spatz_bank_arbiter;
    import spatz_bank_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t q1s[$], q3s[$], q1c[$], q3c[$];

    spatz_bank_arbiter_if if1();
    spatz_bank_arbiter_if if2();
    spatz_bank_arbiter_if if3();

    spatz_bank_arbiter #(.Latency(1), .MaxStall(4)) u_l1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    spatz_bank_arbiter #(.Latency(2), .MaxStall(4)) u_l2 (.clk_i(clk), .rst_i(rst), .bus(if2));
    spatz_bank_arbiter #(.Latency(3), .MaxStall(4)) u_l3 (.clk_i(clk), .rst_i(rst), .bus(if3));

    assign if2.spm_valid_i = if1.spm_valid_i;     assign if3.spm_valid_i = if1.spm_valid_i;
    assign if2.spm_we_i = if1.spm_we_i;           assign if3.spm_we_i = if1.spm_we_i;
    assign if2.spm_addr_i = if1.spm_addr_i;       assign if3.spm_addr_i = if1.spm_addr_i;
    assign if2.spm_wdata_i = if1.spm_wdata_i;     assign if3.spm_wdata_i = if1.spm_wdata_i;
    assign if2.spm_be_i = if1.spm_be_i;           assign if3.spm_be_i = if1.spm_be_i;
    assign if2.cache_valid_i = if1.cache_valid_i; assign if3.cache_valid_i = if1.cache_valid_i;
    assign if2.cache_we_i = if1.cache_we_i;       assign if3.cache_we_i = if1.cache_we_i;
    assign if2.cache_addr_i = if1.cache_addr_i;   assign if3.cache_addr_i = if1.cache_addr_i;
    assign if2.cache_wdata_i = if1.cache_wdata_i; assign if3.cache_wdata_i = if1.cache_wdata_i;
    assign if2.cache_be_i = if1.cache_be_i;       assign if3.cache_be_i = if1.cache_be_i;
    assign if2.bank_rdata_i = if1.bank_rdata_i;   assign if3.bank_rdata_i = if1.bank_rdata_i;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bank_val(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called in the grant cycle: response due Latency cycles later
    task automatic push_rd(input bit spm_rd, input int idx, input logic [7:0] cmask);
        if (spm_rd) begin
            q1s.push_back('{cyc + 1, bank_val(idx)});
            q3s.push_back('{cyc + 3, bank_val(idx)});
        end
        if (cmask != 8'h00) begin
            q1c.push_back('{cyc + 1, 32'(cmask)});
            q3c.push_back('{cyc + 3, 32'(cmask)});
        end
    endtask

    task automatic drive(input bit sv, input bit swe, input logic [10:0] sa,
                         input logic [31:0] sd, input logic [3:0] sbe,
                         input logic [7:0] cv, input logic [7:0] cwe);
        @(negedge clk);
        if1.spm_valid_i   = sv;
        if1.spm_we_i      = swe;
        if1.spm_addr_i    = sa;
        if1.spm_wdata_i   = sd;
        if1.spm_be_i      = sbe;
        if1.cache_valid_i = cv;
        if1.cache_we_i    = cwe;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, '0, '0, '0, '0, '0);
    endtask

    // Response monitor for the Latency=1 instance
    always @(negedge clk) if (mon_en) begin
        exp_t e;
        if (if1.spm_rvalid_o) begin
            if (q1s.size() == 0) chk("l1_spm_spurious", 1, 0);
            else begin
                e = q1s.pop_front();
                chk("l1_spm_cyc", 64'(cyc), 64'(e.cyc));
                chk("l1_spm_data", 64'(if1.spm_rdata_o), 64'(e.val));
            end
        end else chk("l1_spm_rdata_idle", 64'(if1.spm_rdata_o), 0);
        if (if1.cache_rvalid_o != 8'h00) begin
            if (q1c.size() == 0) chk("l1_cache_spurious", 64'(if1.cache_rvalid_o), 0);
            else begin
                e = q1c.pop_front();
                chk("l1_cache_cyc", 64'(cyc), 64'(e.cyc));
                chk("l1_cache_mask", 64'(if1.cache_rvalid_o), 64'(e.val));
                for (int i = 0; i < 8; i++)
                    chk("l1_cache_data", 64'(if1.cache_rdata_o[i]), e.val[i] ? 64'(bank_val(i)) : 64'd0);
            end
        end
    end

    // Response monitor for the Latency=3 instance
    always @(negedge clk) if (mon_en) begin
        exp_t e;
        if (if3.spm_rvalid_o) begin
            if (q3s.size() == 0) chk("l3_spm_spurious", 1, 0);
            else begin
                e = q3s.pop_front();
                chk("l3_spm_cyc", 64'(cyc), 64'(e.cyc));
                chk("l3_spm_data", 64'(if3.spm_rdata_o), 64'(e.val));
            end
        end else chk("l3_spm_rdata_idle", 64'(if3.spm_rdata_o), 0);
        if (if3.cache_rvalid_o != 8'h00) begin
            if (q3c.size() == 0) chk("l3_cache_spurious", 64'(if3.cache_rvalid_o), 0);
            else begin
                e = q3c.pop_front();
                chk("l3_cache_cyc", 64'(cyc), 64'(e.cyc));
                chk("l3_cache_mask", 64'(if3.cache_rvalid_o), 64'(e.val));
            end
        end
    end

    initial begin
        logic [31:0] s0, c0;
        bit          exp_spm;

        for (int i = 0; i < 8; i++) begin
            if1.bank_rdata_i[i]  = bank_val(i);
            if1.cache_addr_i[i]  = 8'h40 + 8'(i);
            if1.cache_wdata_i[i] = 32'hC0DE_0000 + 32'(i);
            if1.cache_be_i[i]    = 4'hF;
        end
        // requests asserted during reset must not be granted
        if1.spm_valid_i = 1; if1.spm_we_i = 1; if1.spm_addr_i = 11'h013;
        if1.spm_wdata_i = 32'h1234; if1.spm_be_i = 4'hF;
        if1.cache_valid_i = 8'hFF; if1.cache_we_i = 8'hFF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_spm_ready", 64'(if1.spm_ready_o), 0);
        chk("rst_cache_ready", 64'(if1.cache_ready_o), 0);
        chk("rst_bank_req", 64'(if1.bank_req_o), 0);
        chk("rst_bank_we", 64'(if1.bank_we_o), 0);
        chk("rst_rvalid", 64'({if1.spm_rvalid_o, if1.cache_rvalid_o}), 0);
        chk("rst_spm_rdata", 64'(if1.spm_rdata_o), 0);
        chk("rst_perf", {if1.spm_stall_cnt_o, if1.cache_stall_cnt_o}, 0);

        idle(1);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // no conflict: SPM bank 3 word 2, cache banks 0 and 5
        drive(1, 0, 11'h013, '0, '0, 8'h21, 8'h00);
        chk("nc_spm_ready", 64'(if1.spm_ready_o), 1);
        chk("nc_cache_ready", 64'(if1.cache_ready_o), 64'h21);
        chk("nc_bank_req", 64'(if1.bank_req_o), 64'h29);
        chk("nc_bank_addr3", 64'(if1.bank_addr_o[3]), 2);
        chk("nc_bank_addr5", 64'(if1.bank_addr_o[5]), 64'h45);
        chk("nc_bank_we", 64'(if1.bank_we_o), 0);
        push_rd(1, 3, 8'h21);
        idle(4);

        // SPM write: bank 1 word 4, no response expected
        drive(1, 1, 11'h021, 32'hDEADBEEF, 4'b0101, 8'h00, 8'h00);
        chk("wr_spm_ready", 64'(if1.spm_ready_o), 1);
        chk("wr_bank_req", 64'(if1.bank_req_o), 64'h02);
        chk("wr_bank_we", 64'(if1.bank_we_o), 64'h02);
        chk("wr_bank_be1", 64'(if1.bank_be_o[1]), 64'h5);
        chk("wr_bank_wdata1", 64'(if1.bank_wdata_o[1]), 64'hDEADBEEF);
        chk("wr_bank_addr1", 64'(if1.bank_addr_o[1]), 4);
        idle(4);

        // back-to-back SPM reads to banks 0, 1, 2
        for (int b = 0; b < 3; b++) begin
            drive(1, 0, 11'(b), '0, '0, 8'h00, 8'h00);
            chk("b2b_spm_ready", 64'(if1.spm_ready_o), 1);
            push_rd(1, b, 8'h00);
        end
        idle(5);

        // starvation on bank 2: 4 SPM grants then 1 forced cache grant
        s0 = if1.spm_stall_cnt_o;
        c0 = if1.cache_stall_cnt_o;
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 11'h002, '0, '0, 8'h04, 8'h00);
            exp_spm = (k % 5) != 4;
            chk("stv_spm_ready", 64'(if1.spm_ready_o), 64'(exp_spm));
            chk("stv_cache_ready", 64'(if1.cache_ready_o), exp_spm ? 64'h0 : 64'h4);
            chk("stv_bank_addr2", 64'(if1.bank_addr_o[2]), exp_spm ? 64'h0 : 64'h42);
            push_rd(exp_spm, 2, exp_spm ? 8'h00 : 8'h04);
        end
        idle(1);
`ifdef SPATZ_BANK_ARB_PERF_EN
        chk("perf_spm_stall", 64'(if1.spm_stall_cnt_o - s0), 2);
        chk("perf_cache_stall", 64'(if1.cache_stall_cnt_o - c0), 8);
`else
        chk("perf_spm_off", 64'(if1.spm_stall_cnt_o), 64'(s0 & 32'h0));
        chk("perf_cache_off", 64'(if1.cache_stall_cnt_o), 0);
`endif
        idle(5);
        chk("drain_q1s", 64'(q1s.size()), 0);
        chk("drain_q3s", 64'(q3s.size()), 0);
        chk("drain_q1c", 64'(q1c.size()), 0);
        chk("drain_q3c", 64'(q3c.size()), 0);

        // reset mid-flight with bank 2's starvation count at 3
        mon_en = 1'b0;
        drive(1, 1, 11'h002, 32'h1, 4'hF, 8'h04, 8'h04);
        drive(1, 1, 11'h002, 32'h1, 4'hF, 8'h04, 8'h04);
        drive(1, 0, 11'h002, '0, '0, 8'h04, 8'h00);
        chk("mf_spm_ready", 64'(if1.spm_ready_o), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mf_ready", 64'({if1.spm_ready_o, if2.spm_ready_o, if3.spm_ready_o,
                             if1.cache_ready_o, if2.cache_ready_o, if3.cache_ready_o}), 0);
        chk("mf_bank_req", 64'({if1.bank_req_o, if2.bank_req_o, if3.bank_req_o}), 0);
        chk("mf_rvalid", 64'({if1.spm_rvalid_o, if2.spm_rvalid_o, if3.spm_rvalid_o,
                              |if1.cache_rvalid_o, |if2.cache_rvalid_o, |if3.cache_rvalid_o}), 0);
        chk("mf_rdata", 64'({if1.spm_rdata_o | if2.spm_rdata_o | if3.spm_rdata_o}), 0);
        repeat (2) @(negedge clk);
        if1.spm_valid_i = 0;
        if1.cache_valid_i = 8'h00;
        rst = 1'b0;
        // counters cleared: 4 SPM grants must precede the forced cache grant
        for (int k = 0; k < 8; k++) begin
            if (k < 5) drive(1, 1, 11'h002, 32'h2, 4'hF, 8'h04, 8'h04);
            else       idle(1);
            if (k < 5) chk("mf_post_spm_ready", 64'(if1.spm_ready_o), 64'(k != 4));
            chk("mf_post_rvalid", 64'({if1.spm_rvalid_o, if2.spm_rvalid_o, if3.spm_rvalid_o,
                                       |if1.cache_rvalid_o, |if2.cache_rvalid_o, |if3.cache_rvalid_o}), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
